mem_op_sequencer: RTL and testbench
===================================

Name: mem_op_sequencer

Overview:
Hardwired control sequencer for the datapath's memory-class instructions: ld, ldi and st. It generates the fetch and execute control-step signals that benches currently hand-drive.
- Adds a memory ready handshake with a bounded timeout.
- Adds continuous or single-instruction run modes.
- Adds illegal-opcode detection.
- Sits beside the CPU datapath and drives its control inputs directly.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory step waits for mem_ready before the error state (1..255)
CONTINUOUS, 1, 1: after Done, refetch while run=1; 0: stop in Idle after each instruction
OP_LD, 5'b00000, ld opcode
OP_LDI, 5'b00001, ldi opcode
OP_ST, 5'b00010, st opcode

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces Idle
run  in  1  start/continue execution
ir_op  in  5  IR[31:27] from datapath IR
mem_ready  in  1  memory completed current read/write this cycle
IncPC, PCin, MARin  out  1 each  PC increment/load, MAR load
Read, MDRin, MDRout, IRin  out  1 each  MDR source select/load/drive, IR load
Grb, Gra, BAout, Rin, Rout  out  1 each  register select/drive/load
Yin, Cout, ADD, Zin, Zlowout  out  1 each  ALU path controls
read_mem, write_mem  out  1 each  memory strobes
step  out  4  current state code (debug)
done  out  1  one-cycle pulse on instruction completion
error  out  1  sticky; set on illegal opcode or timeout
err_code  out  2  00 none, 01 illegal opcode, 10 read timeout, 11 write timeout

Behaviour:
- State register updates on posedge clk; reset clears it asynchronously. Outputs are Moore-decoded from the state register and timeout counter only. No output depends combinationally on run or ir_op.
- Reset values: state=Idle, all control outputs 0, done=0, error=0, err_code=00, timeout counter=0.
- State codes on step: Idle=0, T0..T7=1..8, Done=9, Err=10.
- Idle: all controls 0. run=1 -> T0.
- T0: IncPC, MARin, PCin -> T1.
- T1: Read, MDRin, read_mem.
  - Hold while mem_ready=0; counter increments each held cycle.
  - mem_ready=1 -> T2, counter cleared.
  - Counter reaching MEM_TIMEOUT with mem_ready=0 -> Err, err_code=10.
  - mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT: ready wins.
- T2: MDRout, IRin -> T3.
- T3: ir_op sampled; ir_op not in {OP_LD, OP_LDI, OP_ST} -> Err, err_code=01, no controls asserted. Otherwise Grb, BAout, Yin -> T4.
- T4: Cout, ADD, Zin -> T5.
- T5:
  - ldi: Zlowout, Gra, Rin -> Done.
  - ld/st: Zlowout, MARin -> T6.
- T6:
  - ld: Read, MDRin, read_mem; mem_ready handshake and timeout as T1 (err_code=10) -> T7.
  - st: Gra, Rout, MDRin -> T7.
- T7:
  - ld: MDRout, Gra, Rin -> Done.
  - st: write_mem held until mem_ready=1, timeout -> Err with err_code=11 -> Done.
- Done: done=1 for exactly one cycle.
  - CONTINUOUS=1 and run=1 -> T0.
  - Otherwise -> Idle.
- Err: all controls 0, error=1; held until reset. run is ignored.
- run deasserted mid-instruction does not abort; the instruction completes to Done.
- Reset mid-operation (any state, including mid-handshake): immediate Idle, strobes drop asynchronously, error and err_code cleared.
- ir_op is treated as stable from T3 through T7; the decode is held internally from T3 so later IR changes are ignored.
- At most one of read_mem/write_mem is high in any cycle; write_mem is never high outside st T7.

Test Plan:
1. Reset, run=1, ir_op=00010 (st), mem_ready tied 1 -> step 1,2,3,4,5,6,7,8,9. write_mem high only in step 8. done pulses once at step 9, then step returns to 1 (CONTINUOUS=1).
2. ld with mem_ready low 3 cycles in T1 and 2 cycles in T6 -> T1 lasts 4 cycles, T6 lasts 3 cycles. Gra&Rin asserted only at T7. Total 14 cycles T0..Done.
3. ldi (00001), CONTINUOUS=0 -> Done reached after T5 (6 cycles from T0). Gra, Rin, Zlowout all high at T5. Returns to Idle with run held 1.
4. ir_op=11111 -> Err at T3 step=10, error=1, err_code=01, all controls 0 for 20 further cycles. reset then clears error.
5. st with mem_ready never asserted, MEM_TIMEOUT=15 -> fetch completes (mem_ready pulsed in T1). T7 holds write_mem 15 cycles, then Err with err_code=11.
6. Assert reset during ld T6 with read_mem=1 -> read_mem falls before the next clk edge. step=0, done=0. Deassert reset with run=1 -> normal fetch resumes at T0.

Source files
------------

// File: rtl/mem_op_sequencer.sv
// mem_op_sequencer
// Hardwired control sequencer for the ld / ldi / st memory-class instructions.
// Walks the fetch (T0..T2) and execute (T3..T7) control steps and drives the
// datapath control inputs directly. Memory steps wait on a ready handshake
// that is bounded by MEM_TIMEOUT. Bad opcodes and timeouts park the sequencer
// in a sticky error state, which only reset can clear.
//
// Ports
//   i_clk, i_reset      rising-edge clock; asynchronous active-high reset
//   i_run               start / continue execution
//   i_ir_op[4:0]        opcode field IR[31:27] from the datapath
//   i_mem_ready         memory finished the current read/write this cycle
//   o_inc_pc .. o_zlow_out   datapath control steps
//   o_read_mem, o_write_mem  memory strobes
//   o_step[3:0]         current state code (Idle=0, T0..T7=1..8, Done=9, Err=10)
//   o_done              one-cycle pulse when an instruction completes
//   o_error             sticky error flag
//   o_err_code[1:0]     00 none, 01 illegal opcode, 10 read timeout, 11 write timeout
//
// state | meaning
// IDLE  | waiting for run
// T0    | PC -> MAR, PC increment
// T1    | instruction read, waits on mem_ready
// T2    | MDR -> IR
// T3    | opcode decode, base address -> Y
// T4    | effective address add
// T5    | ldi writeback, or address -> MAR
// T6    | ld read (waits on mem_ready), or st data -> MDR
// T7    | ld writeback, or st write (waits on mem_ready)
// DONE  | completion pulse
// ERR   | parked until reset
module mem_op_sequencer #(
  parameter int         MEM_TIMEOUT = 15,
  parameter bit         CONTINUOUS  = 1'b1,
  parameter logic [4:0] OP_LD       = 5'b00000,
  parameter logic [4:0] OP_LDI      = 5'b00001,
  parameter logic [4:0] OP_ST       = 5'b00010
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic [4:0] i_ir_op,
  input  logic       i_mem_ready,
  output logic       o_inc_pc,
  output logic       o_pc_in,
  output logic       o_mar_in,
  output logic       o_read,
  output logic       o_mdr_in,
  output logic       o_mdr_out,
  output logic       o_ir_in,
  output logic       o_grb,
  output logic       o_gra,
  output logic       o_ba_out,
  output logic       o_r_in,
  output logic       o_r_out,
  output logic       o_y_in,
  output logic       o_c_out,
  output logic       o_add,
  output logic       o_z_in,
  output logic       o_zlow_out,
  output logic       o_read_mem,
  output logic       o_write_mem,
  output logic [3:0] o_step,
  output logic       o_done,
  output logic       o_error,
  output logic [1:0] o_err_code
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_DONE = 4'd9,
    S_ERR  = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    K_LD  = 2'd0,
    K_LDI = 2'd1,
    K_ST  = 2'd2
  } kind_t;

  // Last counter value before a timeout: a wait step lasts at most
  // MEM_TIMEOUT cycles with mem_ready low.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  kind_t      r_kind;
  kind_t      w_kind;
  logic       w_legal;
  logic [1:0] r_err_code;
  logic [1:0] w_err_code_next;

  always_comb begin
    w_legal = 1'b1;
    w_kind  = K_LD;
    if (i_ir_op == OP_LD) begin
      w_kind = K_LD;
    end else if (i_ir_op == OP_LDI) begin
      w_kind = K_LDI;
    end else if (i_ir_op == OP_ST) begin
      w_kind = K_ST;
    end else begin
      w_legal = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_kind     <= K_LD;
      r_err_code <= 2'b00;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_err_code <= w_err_code_next;
      // Decode is captured once so later IR changes cannot alter the flow.
      if (r_state == S_T3) begin
        r_kind <= w_kind;
      end
    end
  end

  // Wait steps: ready wins over timeout when both land on the same cycle.
  always_comb begin
    w_next          = r_state;
    w_cnt_next      = '0;
    w_err_code_next = r_err_code;
    case (r_state)
      S_IDLE: if (i_run) w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1: begin
        if (i_mem_ready) begin
          w_next = S_T2;
        end else if (r_cnt == TMO_LAST) begin
          w_next          = S_ERR;
          w_err_code_next = 2'b10;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_T2:   w_next = S_T3;
      S_T3: begin
        if (w_legal) begin
          w_next = S_T4;
        end else begin
          w_next          = S_ERR;
          w_err_code_next = 2'b01;
        end
      end
      S_T4:   w_next = S_T5;
      S_T5:   w_next = (r_kind == K_LDI) ? S_DONE : S_T6;
      S_T6: begin
        if (r_kind != K_LD || i_mem_ready) begin
          w_next = S_T7;
        end else if (r_cnt == TMO_LAST) begin
          w_next          = S_ERR;
          w_err_code_next = 2'b10;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_T7: begin
        if (r_kind != K_ST || i_mem_ready) begin
          w_next = S_DONE;
        end else if (r_cnt == TMO_LAST) begin
          w_next          = S_ERR;
          w_err_code_next = 2'b11;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_DONE: w_next = (CONTINUOUS && i_run) ? S_T0 : S_IDLE;
      S_ERR:  w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_inc_pc    = 1'b0;
    o_pc_in     = 1'b0;
    o_mar_in    = 1'b0;
    o_read      = 1'b0;
    o_mdr_in    = 1'b0;
    o_mdr_out   = 1'b0;
    o_ir_in     = 1'b0;
    o_grb       = 1'b0;
    o_gra       = 1'b0;
    o_ba_out    = 1'b0;
    o_r_in      = 1'b0;
    o_r_out     = 1'b0;
    o_y_in      = 1'b0;
    o_c_out     = 1'b0;
    o_add       = 1'b0;
    o_z_in      = 1'b0;
    o_zlow_out  = 1'b0;
    o_read_mem  = 1'b0;
    o_write_mem = 1'b0;
    o_done      = 1'b0;
    o_error     = 1'b0;
    case (r_state)
      S_T0: begin
        o_inc_pc = 1'b1;
        o_mar_in = 1'b1;
        o_pc_in  = 1'b1;
      end
      S_T1: begin
        o_read     = 1'b1;
        o_mdr_in   = 1'b1;
        o_read_mem = 1'b1;
      end
      S_T2: begin
        o_mdr_out = 1'b1;
        o_ir_in   = 1'b1;
      end
      S_T3: begin
        o_grb    = 1'b1;
        o_ba_out = 1'b1;
        o_y_in   = 1'b1;
      end
      S_T4: begin
        o_c_out = 1'b1;
        o_add   = 1'b1;
        o_z_in  = 1'b1;
      end
      S_T5: begin
        o_zlow_out = 1'b1;
        if (r_kind == K_LDI) begin
          o_gra  = 1'b1;
          o_r_in = 1'b1;
        end else begin
          o_mar_in = 1'b1;
        end
      end
      S_T6: begin
        o_mdr_in = 1'b1;
        if (r_kind == K_LD) begin
          o_read     = 1'b1;
          o_read_mem = 1'b1;
        end else begin
          o_gra   = 1'b1;
          o_r_out = 1'b1;
        end
      end
      S_T7: begin
        if (r_kind == K_LD) begin
          o_mdr_out = 1'b1;
          o_gra     = 1'b1;
          o_r_in    = 1'b1;
        end else begin
          o_write_mem = 1'b1;
        end
      end
      S_DONE: o_done  = 1'b1;
      S_ERR:  o_error = 1'b1;
      default: ;
    endcase
  end

  assign o_step     = r_state;
  assign o_err_code = r_err_code;

endmodule

// File: tb/tb_mem_op_sequencer.sv
module tb_mem_op_sequencer;

  localparam int TO = 15;
  localparam int OP_LD = 0, OP_LDI = 1, OP_ST = 2, OP_ILL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       rdy;
  logic [4:0] irop;

  logic [1:0] inc_pc, pc_in, mar_in, rd, mdr_in, mdr_out, ir_in, grb, gra, ba_out;
  logic [1:0] r_in, r_out, y_in, c_out, add, z_in, zlow_out, read_mem, write_mem;
  logic [1:0] done, error;
  logic [3:0] step [2];
  logic [1:0] ecode [2];
  logic [26:0] vec [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    // instance 0: continuous mode, instance 1: single-instruction mode
    mem_op_sequencer #(.MEM_TIMEOUT(TO), .CONTINUOUS(g == 0)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_run(run), .i_ir_op(irop), .i_mem_ready(rdy),
      .o_inc_pc(inc_pc[g]), .o_pc_in(pc_in[g]), .o_mar_in(mar_in[g]),
      .o_read(rd[g]), .o_mdr_in(mdr_in[g]), .o_mdr_out(mdr_out[g]), .o_ir_in(ir_in[g]),
      .o_grb(grb[g]), .o_gra(gra[g]), .o_ba_out(ba_out[g]), .o_r_in(r_in[g]),
      .o_r_out(r_out[g]), .o_y_in(y_in[g]), .o_c_out(c_out[g]), .o_add(add[g]),
      .o_z_in(z_in[g]), .o_zlow_out(zlow_out[g]), .o_read_mem(read_mem[g]),
      .o_write_mem(write_mem[g]), .o_step(step[g]), .o_done(done[g]),
      .o_error(error[g]), .o_err_code(ecode[g])
    );
    assign vec[g] = {step[g], inc_pc[g], pc_in[g], mar_in[g], rd[g], mdr_in[g],
                     mdr_out[g], ir_in[g], grb[g], gra[g], ba_out[g], r_in[g],
                     r_out[g], y_in[g], c_out[g], add[g], z_in[g], zlow_out[g],
                     read_mem[g], write_mem[g], done[g], error[g], ecode[g]};
  end

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  int    sel = 0;
  bit    cont = 1'b1;
  bit    need_idle = 1'b1;
  string tag = "reset";

  // expected trace, one entry per clock cycle
  int         q_st[$];
  int         q_op[$];
  int         q_ec[$];
  bit         q_rdy[$];
  bit         q_run[$];
  logic [4:0] q_ir[$];

  // Expected outputs from the step number, instruction class and error code.
  function automatic logic [26:0] exp_vec(int st, int op, int ec);
    logic inc_pc_e = 0, pc_in_e = 0, mar_in_e = 0, rd_e = 0, mdr_in_e = 0;
    logic mdr_out_e = 0, ir_in_e = 0, grb_e = 0, gra_e = 0, ba_out_e = 0;
    logic r_in_e = 0, r_out_e = 0, y_in_e = 0, c_out_e = 0, add_e = 0;
    logic z_in_e = 0, zlow_e = 0, rmem_e = 0, wmem_e = 0, done_e = 0, err_e = 0;
    case (st)
      1: begin inc_pc_e = 1; mar_in_e = 1; pc_in_e = 1; end
      2: begin rd_e = 1; mdr_in_e = 1; rmem_e = 1; end
      3: begin mdr_out_e = 1; ir_in_e = 1; end
      4: begin grb_e = 1; ba_out_e = 1; y_in_e = 1; end
      5: begin c_out_e = 1; add_e = 1; z_in_e = 1; end
      6: begin
        zlow_e = 1;
        if (op == OP_LDI) begin gra_e = 1; r_in_e = 1; end
        else mar_in_e = 1;
      end
      7: begin
        mdr_in_e = 1;
        if (op == OP_LD) begin rd_e = 1; rmem_e = 1; end
        else begin gra_e = 1; r_out_e = 1; end
      end
      8: begin
        if (op == OP_LD) begin mdr_out_e = 1; gra_e = 1; r_in_e = 1; end
        else wmem_e = 1;
      end
      9:  done_e = 1;
      10: err_e = 1;
      default: ;
    endcase
    return {4'(st), inc_pc_e, pc_in_e, mar_in_e, rd_e, mdr_in_e, mdr_out_e, ir_in_e,
            grb_e, gra_e, ba_out_e, r_in_e, r_out_e, y_in_e, c_out_e, add_e, z_in_e,
            zlow_e, rmem_e, wmem_e, done_e, err_e, 2'(ec)};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] rir();
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic push(int st, int op, bit r, bit rn, logic [4:0] ir, int ec);
    q_st.push_back(st); q_op.push_back(op); q_ec.push_back(ec);
    q_rdy.push_back(r); q_run.push_back(rn); q_ir.push_back(ir);
  endtask

  // A memory step with ready held low for w cycles; w >= TO times out.
  task automatic wait_step(int st, int op, int w, output bit tmo);
    tmo = (w >= TO);
    for (int k = 0; k < (tmo ? TO : w); k++) push(st, op, 1'b0, rb(), rir(), 0);
    if (!tmo) push(st, op, 1'b1, rb(), rir(), 0);
  endtask

  task automatic push_err(int ec, int n);
    for (int k = 0; k < n; k++) push(10, 0, rb(), rb(), rir(), ec);
  endtask

  task automatic gen_instr(int op, logic [4:0] opc, int w1, int w6, int w7,
                           bit done_run, int nerr, output bit ended);
    bit tmo;
    ended = 1'b0;
    if (need_idle) begin
      repeat ($urandom_range(0, 2)) push(0, op, rb(), 1'b0, rir(), 0);
      push(0, op, rb(), 1'b1, rir(), 0);
    end
    push(1, op, rb(), rb(), rir(), 0);
    wait_step(2, op, w1, tmo);
    if (tmo) begin push_err(2, nerr); ended = 1'b1; return; end
    push(3, op, rb(), rb(), rir(), 0);
    push(4, op, rb(), rb(), opc, 0);
    if (op == OP_ILL) begin push_err(1, nerr); ended = 1'b1; return; end
    push(5, op, rb(), rb(), rir(), 0);
    push(6, op, rb(), rb(), rir(), 0);
    if (op != OP_LDI) begin
      if (op == OP_LD) wait_step(7, op, w6, tmo);
      else begin tmo = 1'b0; push(7, op, rb(), rb(), rir(), 0); end
      if (tmo) begin push_err(2, nerr); ended = 1'b1; return; end
      if (op == OP_ST) wait_step(8, op, w7, tmo);
      else begin tmo = 1'b0; push(8, op, rb(), rb(), rir(), 0); end
      if (tmo) begin push_err(3, nerr); ended = 1'b1; return; end
    end
    push(9, op, rb(), done_run, rir(), 0);
    need_idle = !(cont && done_run);
  endtask

  task automatic check(logic [26:0] exp, int idx);
    logic [26:0] got;
    got = vec[sel];
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cyc %0d: observed step=%0d vec=%h, expected step=%0d vec=%h",
             tag, idx, got[26:23], got, exp[26:23], exp);
    end
  endtask

  task automatic play(int limit);
    int n;
    n = q_st.size();
    if (limit >= 0 && limit < n) n = limit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(exp_vec(q_st[i], q_op[i], q_ec[i]), i);
      rdy = q_rdy[i]; run = q_run[i]; irop = q_ir[i];
    end
    q_st.delete(); q_op.delete(); q_ec.delete();
    q_rdy.delete(); q_run.delete(); q_ir.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; rdy = 1'b0;
    #1 check(exp_vec(0, 0, 0), -1);
    @(negedge clk);
    rst = 1'b0;
    need_idle = 1'b1;
  endtask

  function automatic int rwait();
    if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) != 0) ? TO - 1 : TO;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    bit ended;
    int idx;
    rst = 1'b1; run = 1'b0; rdy = 1'b0; irop = 5'd0;

    // st with ready always high, back-to-back refetch
    tag = "st_fast"; sel = 0; cont = 1'b1;
    do_reset();
    gen_instr(OP_ST, 5'b00010, 0, 0, 0, 1'b1, 0, ended);
    gen_instr(OP_ST, 5'b00010, 0, 0, 0, 1'b1, 0, ended);
    play(-1);

    // ld with ready delays 3 in T1 and 2 in T6
    tag = "ld_wait";
    do_reset();
    gen_instr(OP_LD, 5'b00000, 3, 2, 0, 1'b1, 0, ended);
    play(-1);

    // ldi in single-instruction mode returns to Idle with run held
    tag = "ldi_single"; sel = 1; cont = 1'b0;
    do_reset();
    gen_instr(OP_LDI, 5'b00001, 0, 0, 0, 1'b1, 0, ended);
    gen_instr(OP_LDI, 5'b00001, 1, 0, 0, 1'b1, 0, ended);
    play(-1);

    // illegal opcode parks in Err for 20 cycles
    tag = "illegal"; sel = 0; cont = 1'b1;
    do_reset();
    gen_instr(OP_ILL, 5'b11111, 0, 0, 0, 1'b1, 20, ended);
    play(-1);

    // write timeout, and read timeout / ready-at-limit boundaries
    tag = "st_timeout";
    do_reset();
    gen_instr(OP_ST, 5'b00010, 0, 0, TO, 1'b1, 4, ended);
    play(-1);
    tag = "rd_edge";
    do_reset();
    gen_instr(OP_LD, 5'b00000, TO - 1, TO - 1, 0, 1'b1, 0, ended);
    gen_instr(OP_ST, 5'b00010, 0, 0, TO - 1, 1'b1, 0, ended);
    gen_instr(OP_LD, 5'b00000, 0, TO, 0, 1'b1, 4, ended);
    play(-1);

    // asynchronous reset during the ld read in T6
    tag = "async_rst";
    do_reset();
    gen_instr(OP_LD, 5'b00000, 0, 10, 0, 1'b1, 0, ended);
    idx = 0;
    for (int i = 0; i < q_st.size(); i++) if (q_st[i] == 7) begin idx = i; break; end
    play(idx + 2);
    @(posedge clk);
    #2 check(exp_vec(7, OP_LD, 0), 0);
    rst = 1'b1;
    #1 check(exp_vec(0, 0, 0), 1);
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    need_idle = 1'b1;
    tag = "after_rst";
    gen_instr(OP_LD, 5'b00000, 1, 0, 0, 1'b1, 0, ended);
    play(-1);

    // randomized instruction streams in both modes
    for (int r = 0; r < 8; r++) begin
      int op, pick;
      tag = "random";
      sel = r % 2;
      cont = (sel == 0);
      do_reset();
      for (int k = 0; k < 6; k++) begin
        pick = $urandom_range(0, 19);
        op = (pick < 6) ? OP_LD : (pick < 11) ? OP_LDI : (pick < 18) ? OP_ST : OP_ILL;
        gen_instr(op,
                  (op == OP_ILL) ? 5'($urandom_range(3, 31)) : 5'(op),
                  rwait(), rwait(), rwait(), ($urandom_range(0, 3) != 0), 3, ended);
        if (ended) break;
      end
      play(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
